// File: rtl/icache_pkg.sv
// Shared CPU defines for the instruction cache: geometry default and FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icache_pkg;

    // Default number of index bits: 2^8 one-word lines.
    localparam int ICACHE_INDEX_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache, one 32-bit word per line.
// Latency: combinational read, write lands at the next rising clk_in.
// Backpressure: none; the caller gates wr_en (valid bits clear on rst_in low).
// Ports: clk_in/rst_in; rd_idx -> rd_vld/rd_tag/rd_dat; wr_en/wr_idx/wr_tag/wr_dat.
module icache_array #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 32 - INDEX_W - 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_vld,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_dat,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_dat
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    assign rd_vld = valid_q[rd_idx];
    assign rd_tag = tag_mem[rd_idx];
    assign rd_dat = data_mem[rd_idx];

    // Only the valid bits need reset; tag/data behind a clear valid bit are don't-care.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_dat;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache, one word per line, single outstanding miss.
// Latency: hit -> response next cycle; miss -> memory latency + 2 cycles.
// Backpressure: fetch_ready_out low during MISS or clear_in; rdy_in low freezes everything.
// Ports: fetch_* request in, instr_* response out, mem_* word read to memory, clear_in flush.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = 32 - INDEX_W - 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_valid_in,
    input  logic [31:0] fetch_pc_in,
    output logic        fetch_ready_out,
    input  logic        clear_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    output logic        mem_valid_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_done_in,
    input  logic [31:0] mem_data_in
);

    icache_state_t state_q;
    logic [31:0]   pc_q;
    // Set when a flush lands while a fill is outstanding: the fill still
    // completes and is written, but its response must not reach IF.
    logic          kill_q;

    logic               rd_vld;
    logic [TAG_W-1:0]   rd_tag;
    logic [31:0]        rd_dat;
    logic               hit;
    logic               accept;
    logic               fill_en;

    assign fetch_ready_out = (state_q == IDLE) && !clear_in;
    assign accept          = rdy_in && fetch_valid_in && fetch_ready_out;
    assign hit             = rd_vld && (rd_tag == fetch_pc_in[31:INDEX_W+2]);
    assign fill_en         = rst_in && rdy_in && (state_q == MISS) && mem_done_in;

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rd_idx  (fetch_pc_in[INDEX_W+1:2]),
        .rd_vld  (rd_vld),
        .rd_tag  (rd_tag),
        .rd_dat  (rd_dat),
        .wr_en   (fill_en),
        .wr_idx  (pc_q[INDEX_W+1:2]),
        .wr_tag  (pc_q[31:INDEX_W+2]),
        .wr_dat  (mem_data_in)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            pc_q            <= '0;
            kill_q          <= 1'b0;
            instr_valid_out <= 1'b0;
            instr_out       <= '0;
            instr_pc_out    <= '0;
            mem_valid_out   <= 1'b0;
            mem_addr_out    <= '0;
        end else if (rdy_in) begin
            // Response is a single-cycle pulse; data/pc hold until the next one.
            instr_valid_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        pc_q   <= fetch_pc_in;
                        kill_q <= 1'b0;
                        if (hit) begin
                            instr_valid_out <= 1'b1;
                            instr_out       <= rd_dat;
                            instr_pc_out    <= fetch_pc_in;
                        end else begin
                            state_q       <= MISS;
                            mem_valid_out <= 1'b1;
                            mem_addr_out  <= {fetch_pc_in[31:2], 2'b00};
                        end
                    end
                end
                MISS: begin
                    if (clear_in) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_done_in) begin
                        state_q       <= IDLE;
                        mem_valid_out <= 1'b0;
                        // A flush in the done cycle itself also kills the response.
                        if (!(kill_q || clear_in)) begin
                            instr_valid_out <= 1'b1;
                            instr_out       <= mem_data_in;
                            instr_pc_out    <= pc_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
